// File: rtl/alu_writeback.sv
// ALU commit stage: architectural flag register plus in-order register-file write queue.
// Latency: accepted result visible on flags, rf_* and busy_mask one cycle later.
// Backpressure: in_ready drops when DEPTH writes are queued or during flush/reset.
module alu_writeback #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [REG_ADDR_W-1:0]      in_rd,
    input  logic                       in_wr_en,
    input  logic                       in_set_flags,
    input  logic                       in_z,
    input  logic                       in_n,
    input  logic                       in_c,
    input  logic                       in_sn,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic                       flag_c,
    output logic                       flag_sn,
    output logic                       carry_out,
    output logic                       rf_valid,
    input  logic                       rf_ready,
    output logic [REG_ADDR_W-1:0]      rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    output logic [(1<<REG_ADDR_W)-1:0] busy_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [3:0]            flags_q, flags_d;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // rst_n gates in_ready so nothing is accepted while reset is held.
    assign in_ready = rst_n && !flush && (cnt_q < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_wr_en && (in_rd != '0);
    assign rf_valid = (cnt_q != '0);
    assign pop      = rf_valid && rf_ready && !flush;

    assign rf_addr   = addr_q[rd_ptr_q];
    assign rf_data   = data_q[rd_ptr_q];
    assign flag_z    = flags_q[3];
    assign flag_n    = flags_q[2];
    assign flag_c    = flags_q[1];
    assign flag_sn   = flags_q[0];
    assign carry_out = flags_q[1];

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        flags_d  = flags_q;
        if (accept && in_set_flags) begin
            flags_d = {in_z, in_n, in_c, in_sn};
        end
        if (flush) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            vld_d    = '0;
        end else begin
            if (push) begin
                vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            // Push and pop never hit the same slot: pop needs count>0, push needs count<DEPTH.
            if (pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            flags_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            flags_q  <= flags_d;
        end
    end

    // Payload storage is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= in_rd;
            data_q[wr_ptr_q] <= in_result;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                busy_mask[addr_q[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a scoreboard of expected register-file writes.
module tb_alu_writeback;

    localparam int DATA_W = 64;
    localparam int AW     = 5;
    localparam int DEPTH  = 2;
    localparam int NR     = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_result = '0;
    logic [AW-1:0]     in_rd = '0;
    logic              in_wr_en = 1'b0;
    logic              in_set_flags = 1'b0;
    logic              in_z = 1'b0, in_n = 1'b0, in_c = 1'b0, in_sn = 1'b0;
    logic              flag_z, flag_n, flag_c, flag_sn, carry_out;
    logic              rf_valid;
    logic              rf_ready = 1'b0;
    logic [AW-1:0]     rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [NR-1:0]     busy_mask;

    alu_writeback #(.DATA_W(DATA_W), .REG_ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_rd(in_rd), .in_wr_en(in_wr_en), .in_set_flags(in_set_flags),
        .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_sn(in_sn),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_sn(flag_sn),
        .carry_out(carry_out),
        .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_data(rf_data),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t       sb[$];
    logic [3:0] mflags = '0;
    int         checks = 0;
    int         errors = 0;
    int         writes = 0;
    bit         acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; checks, updates model, advances one cycle.
    task automatic tick();
        logic [NR-1:0] mb;
        logic          exp_rdy;
        ent_t          e;
        #1;
        if (!rst_n) begin
            sb.delete();
            mflags = '0;
        end
        mb = '0;
        foreach (sb[i]) mb[sb[i].a] = 1'b1;
        exp_rdy = rst_n && !flush && (sb.size() < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("rf_valid", 64'(rf_valid), 64'(sb.size() != 0));
        chk("busy_mask", 64'(busy_mask), 64'(mb));
        chk("flags", 64'({flag_z, flag_n, flag_c, flag_sn}), 64'(mflags));
        chk("carry_out", 64'(carry_out), 64'(mflags[1]));
        acc = in_valid && exp_rdy;
        if (rst_n && !flush && rf_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("rf_addr", 64'(rf_addr), 64'(e.a));
            chk("rf_data", rf_data, e.d);
            writes++;
        end
        if (acc) begin
            if (in_set_flags) mflags = {in_z, in_n, in_c, in_sn};
            if (in_wr_en && in_rd != '0) sb.push_back('{a: in_rd, d: in_result});
        end
        if (rst_n && flush) sb.delete();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic [DATA_W-1:0] d,
                         input logic we, input logic sf, input logic [3:0] f);
        in_valid     = v;
        in_rd        = rd;
        in_result    = d;
        in_wr_en     = we;
        in_set_flags = sf;
        {in_z, in_n, in_c, in_sn} = f;
    endtask

    initial begin
        int w0;
        int pushed;
        int guard;

        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back writes with the register file always ready.
        rf_ready = 1'b1;
        drive(1'b1, 5'd3, 64'h1111, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 5'd4, 64'h2222, 1'b1, 1'b0, 4'h0);
        tick();
        chk("b2b_busy3", 64'(busy_mask[3]), 64'd0);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 4'h0);
        tick();
        tick();

        // Fill the queue with the register file stalled, then drain.
        rf_ready = 1'b0;
        drive(1'b1, 5'd5, 64'h5555, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 5'd6, 64'h6666, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 4'h0);
        #1;
        chk("full_busy", 64'(busy_mask), 64'h60);
        chk("full_rdy", 64'(in_ready), 64'd0);
        tick();
        rf_ready = 1'b1;
        tick();
        tick();
        tick();

        // Flags: load, hold, and an rd=0 write that only updates flags.
        drive(1'b1, 5'd0, 64'h0, 1'b0, 1'b1, 4'b0010);
        tick();
        drive(1'b1, 5'd0, 64'h0, 1'b0, 1'b0, 4'b0000);
        tick();
        chk("hold_carry", 64'(carry_out), 64'd1);
        chk("hold_z", 64'(flag_z), 64'd0);
        drive(1'b1, 5'd0, 64'hDEAD, 1'b1, 1'b1, 4'b1010);
        tick();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 4'h0);
        chk("r0_z", 64'(flag_z), 64'd1);
        chk("r0_norf", 64'(rf_valid), 64'd0);
        tick();

        // Flush with two entries queued, racing an accept and a pop.
        rf_ready = 1'b0;
        drive(1'b1, 5'd7, 64'h7777, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 5'd8, 64'h8888, 1'b1, 1'b0, 4'h0);
        tick();
        w0 = writes;
        flush = 1'b1;
        rf_ready = 1'b1;
        drive(1'b1, 5'd9, 64'h9999, 1'b1, 1'b1, 4'b0101);
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 4'h0);
        tick();
        chk("flush_nopop", 64'(writes - w0), 64'd0);
        tick();

        // Reset asserted mid-stream with two entries queued.
        rf_ready = 1'b0;
        drive(1'b1, 5'd10, 64'hAAAA, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 5'd11, 64'hBBBB, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 4'h0);
        w0 = writes;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rf_ready = 1'b1;
        tick();
        tick();
        chk("rst_nostale", 64'(writes - w0), 64'd0);

        // Wrap-around with random register-file backpressure.
        w0 = writes;
        pushed = 0;
        guard = 0;
        while (pushed < 50 && guard < 2000) begin
            rf_ready = 1'($urandom_range(0, 1));
            drive(1'b1, AW'((pushed % 31) + 1), {$urandom, $urandom}, 1'b1, 1'b0, 4'h0);
            tick();
            if (acc) pushed++;
            guard++;
        end
        chk("wrap_pushed", 64'(pushed), 64'd50);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 4'h0);
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("wrap_writes", 64'(writes - w0), 64'd50);
        chk("wrap_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
